// File: rtl/mem_access_unit_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundle between the MEM-stage load/store unit and its two neighbours: the
// pipeline (request side) and the word-addressed data memory wrapper.
//   req_load/req_store/funct3/addr/wdata : request from the MEM stage
//   mem_addr/mem_we/mem_wdata/mem_rdata  : word port to the memory wrapper
//   load_data/stall/misalign             : results back to the pipeline
// modport slave  : the access unit itself
// modport master : pipeline + memory side (testbench / top-level glue)
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
    logic        req_load;
    logic        req_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;

    modport slave (
        input  req_load, req_store, funct3, addr, wdata, mem_rdata,
        output mem_addr, mem_we, mem_wdata, load_data, stall, misalign
    );

    modport master (
        output req_load, req_store, funct3, addr, wdata, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, load_data, stall, misalign
    );
endinterface

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_unit
// Converts byte/halfword/word loads and stores from the MEM stage into traffic
// on a word-wide memory port. Sub-word stores to RAM are done as a two-cycle
// read-modify-write (read + stall, then write of the merged word). Stores to
// the MMIO page are written directly, zero-extended, without RMW. Misaligned
// accesses are flagged and suppressed.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_access_unit_if.slave (request, memory port, results)
// Parameter:
//   MMIO_BASE : upper 20 address bits selecting the MMIO page
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter logic [19:0] MMIO_BASE = 20'hFFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;

    // Access size decode: funct3[1:0] 00 byte, 01 half, 1x word.
    logic is_byte_c, is_half_c, is_word_c;
    logic misaligned_c, mmio_c, access_c, rmw_start_c;

    assign is_byte_c = (bus.funct3[1:0] == 2'b00);
    assign is_half_c = (bus.funct3[1:0] == 2'b01);
    assign is_word_c = bus.funct3[1];

    assign misaligned_c = (is_half_c & bus.addr[0]) | (is_word_c & (|bus.addr[1:0]));
    assign mmio_c       = (bus.addr[31:12] == MMIO_BASE);
    assign access_c     = bus.req_load | bus.req_store;
    assign rmw_start_c  = (state_q == IDLE) & bus.req_store & ~misaligned_c
                        & ~is_word_c & ~mmio_c;

    // Read-modify-write merge: the new data is replicated onto every lane and
    // the lane enables decide which bytes replace the word read from memory.
    logic [3:0]  lane_en_c;
    logic [31:0] ins_data_c;
    logic [31:0] merged_c;

    assign lane_en_c  = is_half_c ? (bus.addr[1] ? 4'b1100 : 4'b0011)
                                  : (4'b0001 << bus.addr[1:0]);
    assign ins_data_c = is_half_c ? {2{bus.wdata[15:0]}} : {4{bus.wdata[7:0]}};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_c[8*gi +: 8] = lane_en_c[gi] ? ins_data_c[8*gi +: 8]
                                                       : bus.mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Load lane extraction and extension; funct3[2] set means unsigned.
    logic [7:0]  ld_byte_c;
    logic [15:0] ld_half_c;
    logic        ld_signed_c;
    logic [31:0] ld_ext_c;

    always_comb begin
        ld_byte_c = 8'h00;
        case (bus.addr[1:0])
            2'b00:   ld_byte_c = bus.mem_rdata[7:0];
            2'b01:   ld_byte_c = bus.mem_rdata[15:8];
            2'b10:   ld_byte_c = bus.mem_rdata[23:16];
            default: ld_byte_c = bus.mem_rdata[31:24];
        endcase
    end

    assign ld_half_c   = bus.addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    assign ld_signed_c = ~bus.funct3[2];

    always_comb begin
        ld_ext_c = bus.mem_rdata;
        if (is_byte_c)
            ld_ext_c = {{24{ld_signed_c & ld_byte_c[7]}}, ld_byte_c};
        else if (is_half_c)
            ld_ext_c = {{16{ld_signed_c & ld_half_c[15]}}, ld_half_c};
    end

    // Direct store data: full word for SW, zero-extended lane data for MMIO SB/SH.
    logic [31:0] st_direct_c;
    assign st_direct_c = is_word_c ? bus.wdata
                       : is_half_c ? {16'h0000, bus.wdata[15:0]}
                                   : {24'h000000, bus.wdata[7:0]};

    // Memory-port and pipeline outputs. These are combinational from state and
    // inputs so loads and direct stores complete in the request cycle. The
    // reset gate makes mem_we/stall/mem_wdata drop as soon as rst_n falls,
    // which also cancels a pending RMW write.
    always_comb begin
        bus.mem_addr  = bus.addr;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = word_q;
        bus.load_data = 32'h0000_0000;
        bus.stall     = 1'b0;
        bus.misalign  = 1'b0;

        if (state_q == RMW_WR) begin
            bus.mem_addr = addr_q;
            bus.mem_we   = 1'b1;
        end else if (access_c) begin
            if (misaligned_c) begin
                bus.misalign = 1'b1;
            end else if (bus.req_load) begin
                bus.load_data = ld_ext_c;
            end else if (is_word_c || mmio_c) begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = st_direct_c;
            end else begin
                bus.mem_addr = {bus.addr[31:2], 2'b00};
                bus.stall    = 1'b1;
            end
        end

        if (!rst_n) begin
            bus.mem_we    = 1'b0;
            bus.stall     = 1'b0;
            bus.misalign  = 1'b0;
            bus.mem_wdata = 32'h0000_0000;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (rmw_start_c) begin
                    state_d = RMW_WR;
                    addr_d  = {bus.addr[31:2], 2'b00};
                    word_d  = merged_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'h0000_0000;
            word_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Self-checking bench for mem_access_unit: a word memory model behind the
// port, a vector table for single-cycle accesses, hand-written sequences for
// read-modify-write and reset corner cases, and a queue of expected outputs.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(.MMIO_BASE(20'hFFFFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Word memory: combinational read, write at clock edge; preload port
    // shares the single writing process.
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = 8'h00;
    logic [31:0] pre_val = 32'h0;

    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_idx] <= pre_val;
        else if (bus.mem_we)
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    typedef struct {
        string       name;
        logic [31:0] ld;
        logic        we;
        logic        stall;
        logic        mis;
        logic [31:0] maddr;
        logic        chk_addr;
        logic [31:0] wdata;
        logic        chk_wd;
    } exp_t;

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic [31:0] e_ld;
        logic        e_we;
        logic        e_stall;
        logic        e_mis;
        logic [31:0] e_wdata;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_load  = ld;
        bus.req_store = st;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Entered and left at posedge+1.
    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        pre_en  = 1'b1;
        pre_idx = a[9:2];
        pre_val = v;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic push_exp(input string nm, input logic [31:0] ld, input logic we,
                            input logic stall, input logic mis, input logic [31:0] maddr,
                            input logic chk_addr, input logic [31:0] wdata, input logic chk_wd);
        exp_t e;
        e.name = nm; e.ld = ld; e.we = we; e.stall = stall; e.mis = mis;
        e.maddr = maddr; e.chk_addr = chk_addr; e.wdata = wdata; e.chk_wd = chk_wd;
        sb_q.push_back(e);
    endtask

    // Samples at the falling edge, then returns at posedge+1.
    task automatic sample_cycle();
        exp_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            $display("txn %-12s ld=%h we=%b stall=%b mis=%b addr=%h wdata=%h",
                     e.name, bus.load_data, bus.mem_we, bus.stall, bus.misalign,
                     bus.mem_addr, bus.mem_wdata);
            check({e.name, ".load_data"}, bus.load_data, e.ld);
            check({e.name, ".mem_we"},    {31'h0, bus.mem_we},   {31'h0, e.we});
            check({e.name, ".stall"},     {31'h0, bus.stall},    {31'h0, e.stall});
            check({e.name, ".misalign"},  {31'h0, bus.misalign}, {31'h0, e.mis});
            if (e.chk_addr) check({e.name, ".mem_addr"},  bus.mem_addr,  e.maddr);
            if (e.chk_wd)   check({e.name, ".mem_wdata"}, bus.mem_wdata, e.wdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pre,
                           input logic [31:0] e_ld, input logic e_we, input logic e_stall,
                           input logic e_mis, input logic [31:0] e_wd);
        vec_t v;
        v.name = nm; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.pre = pre;
        v.e_ld = e_ld; v.e_we = e_we; v.e_stall = e_stall; v.e_mis = e_mis; v.e_wdata = e_wd;
        vecs.push_back(v);
    endtask

    initial begin
        //       name        ld st  f3      addr           wdata          preload        exp load       we stall mis exp wdata
        add_vec("lw",        1, 0, 3'b010, 32'h0000_0010, 32'h0,         32'h8899AABB, 32'h8899AABB, 0, 0, 0, 32'h0);
        add_vec("lb_neg",    1, 0, 3'b000, 32'h0000_0013, 32'h0,         32'h80FF7F01, 32'hFFFFFF80, 0, 0, 0, 32'h0);
        add_vec("lbu",       1, 0, 3'b100, 32'h0000_0013, 32'h0,         32'h80FF7F01, 32'h00000080, 0, 0, 0, 32'h0);
        add_vec("lh_neg",    1, 0, 3'b001, 32'h0000_0012, 32'h0,         32'h80FF7F01, 32'hFFFF80FF, 0, 0, 0, 32'h0);
        add_vec("lhu",       1, 0, 3'b101, 32'h0000_0012, 32'h0,         32'h80FF7F01, 32'h000080FF, 0, 0, 0, 32'h0);
        add_vec("lb_pos",    1, 0, 3'b000, 32'h0000_0010, 32'h0,         32'h80FF7F01, 32'h00000001, 0, 0, 0, 32'h0);
        add_vec("lh_lo",     1, 0, 3'b001, 32'h0000_0010, 32'h0,         32'h80FF7F01, 32'h00007F01, 0, 0, 0, 32'h0);
        add_vec("lb_lane1",  1, 0, 3'b000, 32'h0000_0011, 32'h0,         32'h80FF7F01, 32'h0000007F, 0, 0, 0, 32'h0);
        add_vec("sw",        0, 1, 3'b010, 32'h0000_0030, 32'hDEADBEEF,  32'h0,        32'h0,        1, 0, 0, 32'hDEADBEEF);
        add_vec("sh_mmio",   0, 1, 3'b001, 32'hFFFF_F060, 32'h1234BEEF,  32'h0,        32'h0,        1, 0, 0, 32'h0000BEEF);
        add_vec("sb_mmio",   0, 1, 3'b000, 32'hFFFF_F061, 32'h5A5A5AC3,  32'h0,        32'h0,        1, 0, 0, 32'h000000C3);
        add_vec("lw_mis",    1, 0, 3'b010, 32'h0000_0022, 32'h0,         32'h12345678, 32'h0,        0, 0, 1, 32'h0);
        add_vec("sh_mis",    0, 1, 3'b001, 32'h0000_0013, 32'h0000BEEF,  32'h12345678, 32'h0,        0, 0, 1, 32'h0);
        add_vec("sw_mis",    0, 1, 3'b010, 32'h0000_0031, 32'hCAFEF00D,  32'h12345678, 32'h0,        0, 0, 1, 32'h0);
        add_vec("no_req",    0, 0, 3'b010, 32'h0000_0044, 32'hFFFFFFFF,  32'h12345678, 32'h0,        0, 0, 0, 32'h0);

        // Reset: even with stores requested, nothing is written or stalled.
        drive(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEADBEEF);
        push_exp("rst_sw", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        sample_cycle();
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'h000000A5);
        push_exp("rst_sb", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        sample_cycle();
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;

        // Single-cycle table.
        foreach (vecs[i]) begin
            preload(vecs[i].addr, vecs[i].pre);
            drive(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            push_exp(vecs[i].name, vecs[i].e_ld, vecs[i].e_we, vecs[i].e_stall, vecs[i].e_mis,
                     vecs[i].addr, !vecs[i].e_mis, vecs[i].e_wdata, vecs[i].e_we);
            sample_cycle();
            idle_inputs();
        end

        // RAM SB: read+stall, then merged write; request held across both cycles.
        preload(32'h20, 32'h11223344);
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'hFFFFFFA5);
        push_exp("sb_rd", 32'h0, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h0, 1'b0);
        sample_cycle();
        push_exp("sb_wr", 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h1122A544, 1'b1);
        sample_cycle();
        idle_inputs();
        check("sb_mem", mem[8], 32'h1122A544);

        // Back-to-back SBs into the same word: second merge sees first write.
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0022, 32'h00000011);
        push_exp("sb2a_rd", 32'h0, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h0, 1'b0);
        sample_cycle();
        push_exp("sb2a_wr", 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h1111A544, 1'b1);
        sample_cycle();
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0023, 32'h00000022);
        push_exp("sb2b_rd", 32'h0, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h0, 1'b0);
        sample_cycle();
        push_exp("sb2b_wr", 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h2211A544, 1'b1);
        sample_cycle();
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0);
        push_exp("lw_after", 32'h2211A544, 1'b0, 1'b0, 1'b0, 32'h20, 1'b1, 32'h0, 1'b0);
        sample_cycle();
        idle_inputs();

        // RAM SH into the upper half.
        preload(32'h24, 32'h01020304);
        drive(1'b0, 1'b1, 3'b001, 32'h0000_0026, 32'h5555CAFE);
        push_exp("sh_rd", 32'h0, 1'b0, 1'b1, 1'b0, 32'h24, 1'b1, 32'h0, 1'b0);
        sample_cycle();
        push_exp("sh_wr", 32'h0, 1'b1, 1'b0, 1'b0, 32'h24, 1'b1, 32'hCAFE0304, 1'b1);
        sample_cycle();
        idle_inputs();
        check("sh_mem", mem[9], 32'hCAFE0304);

        // Reset during RMW_WR: write cancelled, memory unchanged, back in IDLE.
        preload(32'h40, 32'h55667788);
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0040, 32'h00000099);
        push_exp("rsb_rd", 32'h0, 1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 32'h0, 1'b0);
        sample_cycle();
        rst_n = 1'b0;
        push_exp("rsb_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        sample_cycle();
        rst_n = 1'b1;
        idle_inputs();
        check("rst_mem", mem[16], 32'h55667788);
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
        push_exp("rst_lw", 32'h55667788, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 32'h0, 1'b0);
        sample_cycle();
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0041, 32'h00000099);
        push_exp("post_rd", 32'h0, 1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 32'h0, 1'b0);
        sample_cycle();
        push_exp("post_wr", 32'h0, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h55669988, 1'b1);
        sample_cycle();
        idle_inputs();
        check("post_mem", mem[16], 32'h55669988);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_left: got %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
